// File: rtl/err_inject_pkg.sv
// Shared types and constants for the error-injection engine: modes, FSM states, LFSR polynomial/seed.
package err_inject_pkg;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'd0,
        MODE_ONESHOT  = 2'd1,
        MODE_PERIODIC = 2'd2,
        MODE_RANDOM   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Right-shift Galois taps for x^32+x^22+x^2+x+1
    localparam logic [31:0] LFSR_POLY         = 32'h8020_0003;
    localparam logic [31:0] LFSR_DEFAULT_SEED = 32'hACE1_0001;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/err_inject_engine_if.sv
// Upstream/downstream codeword stream bundle; slave = engine side, master = source/sink side.
interface err_inject_engine_if #(
    parameter int DATA_W = 16,
    parameter int CRC_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CRC_W-1:0]  in_crc;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CRC_W-1:0]  out_crc;
    logic              out_injected;

    modport slave (
        input  in_valid, in_data, in_crc, out_ready,
        output in_ready, out_valid, out_data, out_crc, out_injected
    );

    modport master (
        output in_valid, in_data, in_crc, out_ready,
        input  in_ready, out_valid, out_data, out_crc, out_injected
    );
endinterface

// File: rtl/err_lfsr.sv
// 32-bit Galois LFSR, advances one step per cycle while en_i is high; reloads SEED on rst.
module err_lfsr
    import err_inject_pkg::*;
#(
    parameter logic [31:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    output logic [31:0] lfsr_o
);
    logic [31:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (rst)       lfsr_q <= SEED;
        else if (en_i) lfsr_q <= lfsr_step(lfsr_q);
    end

    assign lfsr_o = lfsr_q;
endmodule

// File: rtl/err_inject_engine.sv
// Codeword error injector in a single register slice: latency 1, full throughput,
// in_ready = !out_valid | out_ready so output is held stable under stall.
module err_inject_engine
    import err_inject_pkg::*;
#(
    parameter int          DATA_W    = 16,
    parameter int          CRC_W     = 16,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_0001
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_load,
    input  logic [1:0]              cfg_mode,
    input  logic [DATA_W+CRC_W-1:0] cfg_mask,
    input  logic [15:0]             cfg_period,
    input  logic [7:0]              cfg_limit,
    err_inject_engine_if.slave      sif,
    output logic                    busy,
    output logic [15:0]             inj_count
);
    localparam int CW_W = DATA_W + CRC_W;

    mode_e            mode_q;
    logic [CW_W-1:0]  mask_q;
    logic [15:0]      period_q;
    logic [7:0]       limit_q;
    state_e           state_q, state_d;
    logic [15:0]      wcnt_q, wcnt_d;
    logic [7:0]       arm_inj_q, arm_inj_d;
    logic [15:0]      inj_cnt_q;
    logic             out_valid_q;
    logic [CW_W-1:0]  out_cw_q;
    logic             out_inj_q;

    logic             accept;
    logic [31:0]      lfsr;
    logic [CW_W-1:0]  lfsr_rep;
    logic [CW_W-1:0]  mask_eff;
    logic             inj_hit;
    logic             per_hit;
    logic             limit_hit;
    logic [15:0]      period_m1;

    assign sif.in_ready = !out_valid_q | sif.out_ready;
    assign accept       = sif.in_valid & sif.in_ready;

    err_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .en_i   (accept),
        .lfsr_o (lfsr)
    );

    // Widths beyond 32 bits reuse the LFSR pattern cyclically
    for (genvar g = 0; g < CW_W; g++) begin : g_rep
        assign lfsr_rep[g] = lfsr[g % 32];
    end

    assign period_m1 = (period_q == 16'd0) ? 16'd0 : period_q - 16'd1;
    assign per_hit   = (wcnt_q == period_m1);
    assign limit_hit = (limit_q != 8'd0) && ((arm_inj_q + 8'd1) == limit_q);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        arm_inj_d = arm_inj_q;
        if (accept && state_q == ST_ARMED) begin
            if (mode_q == MODE_PERIODIC) wcnt_d = per_hit ? 16'd0 : wcnt_q + 16'd1;
            if (inj_hit) arm_inj_d = arm_inj_q + 8'd1;
            if (mode_q == MODE_ONESHOT)   state_d = ST_DONE;
            else if (inj_hit && limit_hit) state_d = ST_DONE;
        end
        // A coincident word above still sees the old config; the reload wins for the next word
        if (cfg_load) begin
            state_d   = (mode_e'(cfg_mode) == MODE_OFF) ? ST_IDLE : ST_ARMED;
            wcnt_d    = 16'd0;
            arm_inj_d = 8'd0;
        end
    end

    always_comb begin
        mask_eff = '0;
        inj_hit  = 1'b0;
        busy     = (state_q == ST_ARMED);
        if (state_q == ST_ARMED) begin
            case (mode_q)
                MODE_ONESHOT: begin
                    mask_eff = mask_q;
                    inj_hit  = 1'b1;
                end
                MODE_PERIODIC: begin
                    if (per_hit) begin
                        mask_eff = mask_q;
                        inj_hit  = 1'b1;
                    end
                end
                MODE_RANDOM: begin
                    mask_eff = mask_q & lfsr_rep;
                    inj_hit  = |mask_eff;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= MODE_OFF;
            mask_q      <= '0;
            period_q    <= 16'd0;
            limit_q     <= 8'd0;
            wcnt_q      <= 16'd0;
            arm_inj_q   <= 8'd0;
            inj_cnt_q   <= 16'd0;
            out_valid_q <= 1'b0;
            out_cw_q    <= '0;
            out_inj_q   <= 1'b0;
        end else begin
            wcnt_q    <= wcnt_d;
            arm_inj_q <= arm_inj_d;
            if (cfg_load) begin
                mode_q   <= mode_e'(cfg_mode);
                mask_q   <= cfg_mask;
                period_q <= cfg_period;
                limit_q  <= cfg_limit;
            end
            if (accept) begin
                out_valid_q <= 1'b1;
                out_cw_q    <= {sif.in_data, sif.in_crc} ^ mask_eff;
                out_inj_q   <= inj_hit;
            end else if (sif.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (accept && inj_hit && inj_cnt_q != 16'hFFFF) inj_cnt_q <= inj_cnt_q + 16'd1;
        end
    end

    assign sif.out_valid    = out_valid_q;
    assign sif.out_data     = out_cw_q[CW_W-1:CRC_W];
    assign sif.out_crc      = out_cw_q[CRC_W-1:0];
    assign sif.out_injected = out_inj_q;
    assign inj_count        = inj_cnt_q;
endmodule

// File: tb/tb_err_inject_engine.sv
// Directed bench for err_inject_engine: oneshot, periodic, random, reload races, stalls, reset.
module tb_err_inject_engine;
    localparam logic [31:0] SEED = 32'hACE1_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_load;
    logic [1:0]  cfg_mode;
    logic [31:0] cfg_mask;
    logic [15:0] cfg_period;
    logic [7:0]  cfg_limit;
    logic        busy;
    logic [15:0] inj_count;

    int          vectors    = 0;
    int          miscompares = 0;
    logic [31:0] lfsr_m;
    int          exp_cnt;

    err_inject_engine_if #(.DATA_W(16), .CRC_W(16)) bus ();

    err_inject_engine #(.DATA_W(16), .CRC_W(16), .LFSR_SEED(SEED)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_load   (cfg_load),
        .cfg_mode   (cfg_mode),
        .cfg_mask   (cfg_mask),
        .cfg_period (cfg_period),
        .cfg_limit  (cfg_limit),
        .sif        (bus),
        .busy       (busy),
        .inj_count  (inj_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] m, input logic [31:0] k,
                        input logic [15:0] p, input logic [7:0] l);
        cfg_mode = m; cfg_mask = k; cfg_period = p; cfg_limit = l;
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
    endtask

    // Holds in_valid until accepted; optional cfg_load in the first offered cycle
    task automatic send(input logic [15:0] d, input logic [15:0] c, input logic ld);
        int   guard = 0;
        logic acc   = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = d; bus.in_crc = c;
        cfg_load = ld;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            step();
            cfg_load = 1'b0;
            guard++;
        end
        bus.in_valid = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
        else      lfsr_m = lfsr_next(lfsr_m);
    endtask

    initial begin
        logic [31:0] e;
        logic        ei;
        logic        armed_m;
        int          acnt;
        logic [15:0] d16;

        rst = 1'b1; cfg_load = 1'b0; cfg_mode = 2'd0; cfg_mask = 32'h0;
        cfg_period = 16'd0; cfg_limit = 8'd0;
        bus.in_valid = 1'b0; bus.in_data = 16'h0; bus.in_crc = 16'h0; bus.out_ready = 1'b1;
        lfsr_m = SEED; exp_cnt = 0;
        step(); step();
        rst = 1'b0;

        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_cw", {bus.out_data, bus.out_crc}, 0);
        chk("rst_out_inj", bus.out_injected, 0);
        chk("rst_busy", busy, 0);
        chk("rst_inj_count", inj_count, 0);

        // IDLE passes untouched
        send(16'hBEEF, 16'hCAFE, 1'b0);
        chk("idle_cw", {bus.out_data, bus.out_crc}, 32'hBEEF_CAFE);
        chk("idle_inj", bus.out_injected, 0);

        // ONESHOT
        load(2'd1, 32'h0000_0001, 16'd0, 8'd0);
        chk("os_busy", busy, 1);
        for (int i = 1; i <= 3; i++) begin
            send(16'h1234, 16'hABCD, 1'b0);
            chk("os_valid", bus.out_valid, 1);
            chk("os_cw", {bus.out_data, bus.out_crc}, (i == 1) ? 32'h1234_ABCC : 32'h1234_ABCD);
            chk("os_inj", bus.out_injected, (i == 1));
            chk("os_busy_after", busy, 0);
        end
        exp_cnt = 1;
        chk("os_count", inj_count, exp_cnt);

        // PERIODIC period 4 limit 2
        load(2'd2, 32'hFFFF_0000, 16'd4, 8'd2);
        for (int i = 1; i <= 12; i++) begin
            d16 = i[15:0];
            ei  = (i == 4) || (i == 8);
            send(d16, d16, 1'b0);
            chk("per_cw", {bus.out_data, bus.out_crc}, {d16, d16} ^ (ei ? 32'hFFFF_0000 : 32'h0));
            chk("per_inj", bus.out_injected, ei);
            chk("per_busy", busy, (i < 8));
        end
        exp_cnt += 2;
        chk("per_count", inj_count, exp_cnt);

        // cfg_load coincident with an accepted word
        load(2'd2, 32'h0000_00FF, 16'd3, 8'd0);
        send(16'h0001, 16'h1000, 1'b0);
        send(16'h0002, 16'h2000, 1'b0);
        cfg_mode = 2'd2; cfg_mask = 32'h0000_FF00; cfg_period = 16'd3; cfg_limit = 8'd0;
        send(16'h0003, 16'h3000, 1'b1);
        chk("race_cw", {bus.out_data, bus.out_crc}, 32'h0003_30FF);
        chk("race_inj", bus.out_injected, 1);
        send(16'h0004, 16'h4000, 1'b0);
        chk("race_idx0", bus.out_injected, 0);
        send(16'h0005, 16'h5000, 1'b0);
        chk("race_idx1", bus.out_injected, 0);
        send(16'h0006, 16'h6000, 1'b0);
        chk("race_idx2_cw", {bus.out_data, bus.out_crc}, 32'h0006_6000 ^ 32'h0000_FF00);
        exp_cnt += 2;
        chk("race_count", inj_count, exp_cnt);

        // RANDOM all-ones mask against golden LFSR
        load(2'd3, 32'hFFFF_FFFF, 16'd0, 8'd0);
        for (int i = 0; i < 256; i++) begin
            d16 = i[15:0] * 16'd37;
            e   = {d16, ~d16} ^ lfsr_m;
            ei  = (lfsr_m != 32'h0);
            send(d16, ~d16, 1'b0);
            chk("rnd_cw", {bus.out_data, bus.out_crc}, e);
            chk("rnd_inj", bus.out_injected, ei);
        end
        exp_cnt += 256;
        chk("rnd_count", inj_count, exp_cnt);

        // RANDOM sparse mask with limit 3
        load(2'd3, 32'h0000_0001, 16'd0, 8'd3);
        armed_m = 1'b1; acnt = 0;
        for (int i = 0; i < 24; i++) begin
            ei = armed_m && lfsr_m[0];
            send(16'h00AA, 16'h5500, 1'b0);
            chk("rlim_cw", {bus.out_data, bus.out_crc}, 32'h00AA_5500 ^ {31'h0, ei});
            chk("rlim_inj", bus.out_injected, ei);
            if (ei) begin
                acnt++; exp_cnt++;
                if (acnt == 3) armed_m = 1'b0;
            end
            chk("rlim_busy", busy, armed_m);
        end
        chk("rlim_count", inj_count, exp_cnt);

        // period 0 behaves as 1; limit 2 ends after second word
        load(2'd2, 32'h8000_0000, 16'd0, 8'd2);
        send(16'h0000, 16'h0000, 1'b0);
        chk("p0_w1", {bus.out_data, bus.out_crc}, 32'h8000_0000);
        chk("p0_busy1", busy, 1);
        send(16'h0000, 16'h0000, 1'b0);
        chk("p0_w2", bus.out_injected, 1);
        chk("p0_busy2", busy, 0);
        send(16'h0000, 16'h0000, 1'b0);
        chk("p0_w3", bus.out_injected, 0);
        exp_cnt += 2;

        // mode OFF reload drops back to IDLE
        load(2'd2, 32'hFFFF_FFFF, 16'd1, 8'd0);
        chk("off_pre_busy", busy, 1);
        load(2'd0, 32'hFFFF_FFFF, 16'd1, 8'd0);
        chk("off_busy", busy, 0);
        send(16'h1111, 16'h2222, 1'b0);
        chk("off_cw", {bus.out_data, bus.out_crc}, 32'h1111_2222);

        // random backpressure, PERIODIC period 1, 1000 words
        load(2'd2, 32'h0F0F_0F0F, 16'd1, 8'd0);
        begin
            int          sent = 0, rcvd = 0, cyc = 0;
            logic [31:0] q[$];
            logic        hold_pend = 1'b0;
            logic [31:0] hold_cw = 32'h0;
            logic        ain, aout;
            while (rcvd < 1000 && cyc < 6000) begin
                bus.in_valid  = (sent < 1000);
                bus.in_data   = sent[15:0];
                bus.in_crc    = ~sent[15:0];
                bus.out_ready = ($urandom_range(0, 9) >= 3);
                @(negedge clk);
                if (hold_pend) begin
                    chk("hold_valid", bus.out_valid, 1);
                    chk("hold_cw", {bus.out_data, bus.out_crc}, hold_cw);
                    hold_pend = 1'b0;
                end
                ain  = bus.in_valid & bus.in_ready;
                aout = bus.out_valid & bus.out_ready;
                if (aout) begin
                    if (q.size() == 0) chk("stall_extra", 1, 0);
                    else begin
                        e = q.pop_front();
                        chk("stall_order", {bus.out_data, bus.out_crc}, e);
                        chk("stall_inj", bus.out_injected, 1);
                    end
                    rcvd++;
                end
                if (bus.out_valid && !bus.out_ready) begin
                    hold_pend = 1'b1;
                    hold_cw   = {bus.out_data, bus.out_crc};
                end
                if (ain) begin
                    q.push_back({sent[15:0], ~sent[15:0]} ^ 32'h0F0F_0F0F);
                    sent++;
                    lfsr_m = lfsr_next(lfsr_m);
                end
                step();
                cyc++;
            end
            bus.in_valid = 1'b0; bus.out_ready = 1'b1;
            chk("stall_rcvd", rcvd, 1000);
            chk("stall_queue_empty", q.size(), 0);
        end
        exp_cnt += 1000;
        chk("stall_count", inj_count, exp_cnt);

        // reset while a word is stalled in the slice
        bus.out_ready = 1'b0;
        send(16'h7777, 16'h8888, 1'b0);
        chk("pre_rst_valid", bus.out_valid, 1);
        chk("pre_rst_in_ready", bus.in_ready, 0);
        rst = 1'b1; cfg_load = 1'b1; cfg_mode = 2'd1;
        step();
        rst = 1'b0; cfg_load = 1'b0;
        lfsr_m = SEED; exp_cnt = 0;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_count", inj_count, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        chk("mid_rst_busy", busy, 0);
        bus.out_ready = 1'b1;
        load(2'd3, 32'hFFFF_FFFF, 16'd0, 8'd0);
        e = 32'h0 ^ lfsr_m;
        send(16'h0000, 16'h0000, 1'b0);
        chk("post_rst_seed", {bus.out_data, bus.out_crc}, e);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
